// File: rtl/ycc_pkg.sv
// Shared constants for the YCbCr-to-RGB converter: Q8 coefficients and datapath widths.
package ycc_pkg;

  localparam int unsigned PixW = 8;
  localparam int unsigned AccW = 19;

  localparam int OFFSET    = 128;
  localparam int COEF_CR_R = 359;
  localparam int COEF_CB_G = 88;
  localparam int COEF_CR_G = 183;
  localparam int COEF_CB_B = 454;

endpackage

// File: rtl/ycc_clamp8.sv
// Drops the Q8 fraction of a signed accumulator and saturates it to an unsigned 8-bit pixel.
module ycc_clamp8
  import ycc_pkg::*;
(
  input  logic signed [AccW-1:0] acc,
  output logic        [PixW-1:0] pix,
  output logic                   clip
);

  logic signed [AccW-1:0] shifted;

  assign shifted = acc >>> 8;

  always_comb begin
    pix  = shifted[PixW-1:0];
    clip = 1'b0;
    if (shifted[AccW-1]) begin
      pix  = '0;
      clip = 1'b1;
    end else if (|shifted[AccW-2:PixW]) begin
      pix  = '1;
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/ycbcr2rgb.sv
// Three-stage YCbCr-to-RGB converter with valid/ready flow control and a per-frame clip counter.
module ycbcr2rgb
  import ycc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PixW-1:0]  img_Y,
  input  logic [PixW-1:0]  img_Cb,
  input  logic [PixW-1:0]  img_Cr,
  input  logic             in_sof,
  input  logic             in_eol,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PixW-1:0]  img_R,
  output logic [PixW-1:0]  img_G,
  output logic [PixW-1:0]  img_B,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      clip_count
);

  localparam logic signed [AccW-1:0] OffAcc  = AccW'(OFFSET);
  localparam logic signed [AccW-1:0] CoefCrR = AccW'(COEF_CR_R);
  localparam logic signed [AccW-1:0] CoefCbG = AccW'(COEF_CB_G);
  localparam logic signed [AccW-1:0] CoefCrG = AccW'(COEF_CR_G);
  localparam logic signed [AccW-1:0] CoefCbB = AccW'(COEF_CB_B);

  logic en;
  logic v1, v2, v3;
  logic sof1, eol1, sof2, eol2;

  assign en       = !v3 || out_ready;
  assign in_ready = en;
  assign out_valid = v3;

  // Stage 1 inputs: zero-extended luma in Q8 and signed chroma offsets
  logic signed [AccW-1:0] y_ext, dcb, dcr;
  assign y_ext = $signed({{(AccW-PixW){1'b0}}, img_Y}) <<< 8;
  assign dcb   = $signed({{(AccW-PixW){1'b0}}, img_Cb}) - OffAcc;
  assign dcr   = $signed({{(AccW-PixW){1'b0}}, img_Cr}) - OffAcc;

  logic signed [AccW-1:0] y1, p_cr_r, p_cb_g, p_cr_g, p_cb_b;
  logic signed [AccW-1:0] r_acc, g_acc, b_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; sof1 <= 1'b0; eol1 <= 1'b0;
      y1 <= '0; p_cr_r <= '0; p_cb_g <= '0; p_cr_g <= '0; p_cb_b <= '0;
      v2 <= 1'b0; sof2 <= 1'b0; eol2 <= 1'b0;
      r_acc <= '0; g_acc <= '0; b_acc <= '0;
    end else if (en) begin
      v1     <= in_valid;
      sof1   <= in_sof;
      eol1   <= in_eol;
      y1     <= y_ext;
      p_cr_r <= CoefCrR * dcr;
      p_cb_g <= CoefCbG * dcb;
      p_cr_g <= CoefCrG * dcr;
      p_cb_b <= CoefCbB * dcb;
      v2     <= v1;
      sof2   <= sof1;
      eol2   <= eol1;
      r_acc  <= y1 + p_cr_r + OffAcc;
      g_acc  <= y1 - p_cb_g - p_cr_g + OffAcc;
      b_acc  <= y1 + p_cb_b + OffAcc;
    end
  end

  logic [PixW-1:0] r_pix, g_pix, b_pix;
  logic            r_clip, g_clip, b_clip;

  ycc_clamp8 u_clamp_r (.acc(r_acc), .pix(r_pix), .clip(r_clip));
  ycc_clamp8 u_clamp_g (.acc(g_acc), .pix(g_pix), .clip(g_clip));
  ycc_clamp8 u_clamp_b (.acc(b_acc), .pix(b_pix), .clip(b_clip));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0; out_sof <= 1'b0; out_eol <= 1'b0;
      img_R <= '0; img_G <= '0; img_B <= '0;
    end else if (en) begin
      v3      <= v2;
      out_sof <= sof2;
      out_eol <= eol2;
      img_R   <= r_pix;
      img_G   <= g_pix;
      img_B   <= b_pix;
    end
  end

  // A new frame's clear takes priority over an increment from the previous frame's tail
  logic sof_accept, clip_inc;
  assign sof_accept = in_valid && in_ready && in_sof;
  assign clip_inc   = en && v2 && (r_clip || g_clip || b_clip) && (clip_count != 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= '0;
    end else if (sof_accept) begin
      clip_count <= '0;
    end else if (clip_inc) begin
      clip_count <= clip_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed checks of ycbcr2rgb: colour vectors, backpressure ordering, and mid-stream reset.
module tb_ycbcr2rgb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] img_Y, img_Cb, img_Cr;
  logic       in_sof, in_eol, in_valid, in_ready;
  logic [7:0] img_R, img_G, img_B;
  logic       out_sof, out_eol, out_valid, out_ready;
  logic [15:0] clip_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ycbcr2rgb dut (
    .clk(clk), .rst_n(rst_n),
    .img_Y(img_Y), .img_Cb(img_Cb), .img_Cr(img_Cr),
    .in_sof(in_sof), .in_eol(in_eol), .in_valid(in_valid), .in_ready(in_ready),
    .img_R(img_R), .img_G(img_G), .img_B(img_B),
    .out_sof(out_sof), .out_eol(out_eol), .out_valid(out_valid), .out_ready(out_ready),
    .clip_count(clip_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] y, cb, cr, input logic sof, eol, vld);
    img_Y = y; img_Cb = cb; img_Cr = cr; in_sof = sof; in_eol = eol; in_valid = vld;
  endtask

  // One isolated pixel: not visible after two edges, visible after the third.
  task automatic run_one(input string tag, input logic [7:0] y, cb, cr, input logic sof, eol,
                         input logic [7:0] er, eg, eb, input logic [15:0] ecnt);
    @(negedge clk);
    out_ready = 1'b1;
    drive(y, cb, cr, sof, eol, 1'b1);
    @(negedge clk);
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_R"}, {24'd0, img_R}, {24'd0, er});
    check({tag, "_G"}, {24'd0, img_G}, {24'd0, eg});
    check({tag, "_B"}, {24'd0, img_B}, {24'd0, eb});
    check({tag, "_sof"}, {31'd0, out_sof}, {31'd0, sof});
    check({tag, "_eol"}, {31'd0, out_eol}, {31'd0, eol});
    check({tag, "_cnt"}, {16'd0, clip_count}, {16'd0, ecnt});
  endtask

  logic [7:0] ys [6];
  int sent, got_n, prev_c;

  initial begin
    ys[0] = 8'd10; ys[1] = 8'd20; ys[2] = 8'd30;
    ys[3] = 8'd40; ys[4] = 8'd50; ys[5] = 8'd60;
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_rgb", {8'd0, img_R, img_G, img_B}, 32'd0);
    check("rst_marks", {30'd0, out_sof, out_eol}, 32'd0);
    check("rst_cnt", {16'd0, clip_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_one("grey",  8'd128, 8'd128, 8'd128, 1'b1, 1'b0, 8'd128, 8'd128, 8'd128, 16'd0);
    run_one("redsat", 8'd255, 8'd128, 8'd255, 1'b0, 1'b0, 8'd255, 8'd164, 8'd255, 16'd1);
    run_one("zero",  8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 8'd0,   8'd136, 8'd0,   16'd2);
    run_one("edge",  8'd76,  8'd85,  8'd255, 1'b0, 1'b1, 8'd254, 8'd0,   8'd0,   16'd2);

    // Backpressure: out_ready low for cycles 2..9 while six grey pixels stream in.
    sent = 0; got_n = 0; prev_c = -1;
    for (int c = 0; c < 60 && got_n < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c < 10);
      #1;
      if (out_valid) begin
        if (out_ready) begin
          check("bp_R", {24'd0, img_R}, {24'd0, ys[got_n]});
          check("bp_G", {24'd0, img_G}, {24'd0, ys[got_n]});
          if (prev_c >= 10) check("bp_rate", c, prev_c + 1);
          prev_c = c;
          got_n++;
        end else begin
          check("bp_hold_R", {24'd0, img_R}, {24'd0, ys[got_n]});
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
      end
      if (in_ready && sent < 6) begin
        drive(ys[sent], 8'd128, 8'd128, 1'b0, sent == 5, 1'b1);
        sent++;
      end else begin
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      end
    end
    check("bp_count", got_n, 6);
    out_ready = 1'b1;
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst_cnt", {16'd0, clip_count}, 32'd2);

    // Mid-stream reset with clipping pixels in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_cnt", {16'd0, clip_count}, 32'd0);
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("mrst_out_valid2", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    run_one("post_rst", 8'd200, 8'd128, 8'd128, 1'b1, 1'b0, 8'd200, 8'd200, 8'd200, 16'd0);
    @(negedge clk);
    check("drained", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
